// File: rtl/pc_pkg.sv
// Shared types, default addresses and the PC alignment helper for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_RET,
    SEL_JMP,
    SEL_BR,
    SEL_EXC
  } next_sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;

  // Clears the low log2(inst_bytes) bits; inst_bytes must be a power of two.
  function automatic logic [63:0] align_pc(input logic [63:0] pc, input int unsigned inst_bytes);
    return pc & ~(64'(inst_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: top pointer mod DEPTH, saturating count, sticky overflow.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    top_d      = top_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (clear) begin
      top_d   = '0;
      count_d = '0;
    end else if (push) begin
      // When full, top+1 is the oldest slot, so the write drops it.
      top_d        = top_q + PTR_W'(1);
      mem_d[top_d] = push_data;
      if (count_q == FULL) overflow_d = 1'b1;
      else                 count_d    = count_q + CNT_W'(1);
    end else if (pop && count_q != '0) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      top_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      top_q      <= top_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(negedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign top_data = mem_q[top_q];
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with fixed-priority redirect arbitration and return-address prediction.
module pc_gen import pc_pkg::*; #(
  parameter int unsigned          PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [PC_WIDTH-1:0]  EXC_VECTOR = PC_WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned          INST_BYTES = 4,
  parameter int unsigned          RAS_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                exc_req,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                jmp_req,
  input  logic                call_req,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic [PC_WIDTH-1:0] link_addr,
  input  logic                ret_req,
  input  logic [PC_WIDTH-1:0] ret_fallback,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus,
  output logic                redirected,
  output logic                ras_empty,
  output logic                ras_overflow
);

  function automatic logic [PC_WIDTH-1:0] align(input logic [PC_WIDTH-1:0] v);
    return PC_WIDTH'(align_pc(64'(v), INST_BYTES));
  endfunction

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                redirected_q, redirected_d;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push, ras_pop, ras_clear;
  next_sel_e           sel;

  assign pc_plus = pc_q + PC_WIDTH'(INST_BYTES);

  always_comb begin
    sel = SEL_SEQ;
    if (exc_req)                  sel = SEL_EXC;
    else if (br_taken)            sel = SEL_BR;
    else if (jmp_req || call_req) sel = SEL_JMP;
    else if (ret_req)             sel = SEL_RET;
  end

  // A stall freezes everything except an exception, so RAS side effects are gated here too.
  always_comb begin
    pc_d         = pc_q;
    redirected_d = redirected_q;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    ras_clear    = exc_req;
    if (exc_req || !stall) begin
      redirected_d = (sel != SEL_SEQ);
      unique case (sel)
        SEL_EXC: pc_d = align(EXC_VECTOR);
        SEL_BR:  pc_d = align(br_target);
        SEL_JMP: begin
          pc_d     = align(jmp_target);
          ras_push = call_req;
        end
        SEL_RET: begin
          pc_d    = ras_empty ? align(ret_fallback) : align(ras_top);
          ras_pop = !ras_empty;
        end
        default: pc_d = align(pc_plus);
      endcase
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= align(RESET_PC);
      redirected_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redirected_q <= redirected_d;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (link_addr),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_overflow)
  );

  assign pc_out     = pc_q;
  assign redirected = redirected_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: falling-edge updates, outputs sampled 1ns after each falling edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, exc_req, br_taken, jmp_req, call_req, ret_req;
  logic [31:0] br_target, jmp_target, link_addr, ret_fallback;
  logic [31:0] pc_out, pc_plus;
  logic        redirected, ras_empty, ras_overflow;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen #(
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h0000_0180),
    .INST_BYTES (4),
    .RAS_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .exc_req      (exc_req),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_req      (jmp_req),
    .call_req     (call_req),
    .jmp_target   (jmp_target),
    .link_addr    (link_addr),
    .ret_req      (ret_req),
    .ret_fallback (ret_fallback),
    .pc_out       (pc_out),
    .pc_plus      (pc_plus),
    .redirected   (redirected),
    .ras_empty    (ras_empty),
    .ras_overflow (ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; exc_req = 0; br_taken = 0; jmp_req = 0; call_req = 0; ret_req = 0;
  endtask

  task automatic do_jmp(input logic [31:0] tgt);
    idle(); jmp_req = 1; jmp_target = tgt;
    tick(); idle();
  endtask

  task automatic do_call(input logic [31:0] tgt, input logic [31:0] link);
    idle(); call_req = 1; jmp_target = tgt; link_addr = link;
    tick(); idle();
  endtask

  task automatic do_ret();
    idle(); ret_req = 1;
    tick(); idle();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_rets [5];
    exp_rets[0] = 32'h50; exp_rets[1] = 32'h40; exp_rets[2] = 32'h30;
    exp_rets[3] = 32'h20; exp_rets[4] = 32'h800;

    reset = 1; idle();
    br_target = '0; jmp_target = '0; link_addr = '0; ret_fallback = 32'h800;
    #1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_pc_plus", pc_plus, 32'h4);
    check("rst_redir", {31'b0, redirected}, 32'd0);
    check("rst_empty", {31'b0, ras_empty}, 32'd1);
    check("rst_ovf", {31'b0, ras_overflow}, 32'd0);
    #20 reset = 0;

    tick(); check("seq1", pc_out, 32'h4);
    tick(); check("seq2", pc_out, 32'h8);
    tick(); check("seq3", pc_out, 32'hC);
    check("seq_redir", {31'b0, redirected}, 32'd0);
    tick(); check("seq4", pc_out, 32'h10);

    stall = 1; br_taken = 1; br_target = 32'h100;
    tick(); check("stall1", pc_out, 32'h10);
    tick(); check("stall2", pc_out, 32'h10);
    check("stall_redir", {31'b0, redirected}, 32'd0);
    stall = 0;
    tick(); check("br_pc", pc_out, 32'h100);
    check("br_redir", {31'b0, redirected}, 32'd1);
    idle();
    tick(); check("after_br", pc_out, 32'h104);
    check("after_br_redir", {31'b0, redirected}, 32'd0);

    do_jmp(32'h20);
    check("jmp_pc", pc_out, 32'h20);
    do_call(32'h400, 32'h28);
    check("call_pc", pc_out, 32'h400);
    check("call_nonempty", {31'b0, ras_empty}, 32'd0);
    do_ret();
    check("ret_pc", pc_out, 32'h28);
    check("ret_empty", {31'b0, ras_empty}, 32'd1);
    check("ret_redir", {31'b0, redirected}, 32'd1);

    // jmp_req together with call_req must still push the link.
    idle(); jmp_req = 1; call_req = 1; jmp_target = 32'h600; link_addr = 32'h2C;
    tick(); idle();
    check("jmpcall_pc", pc_out, 32'h600);
    do_ret();
    check("jmpcall_ret", pc_out, 32'h2C);

    // Stalled ret must not pop.
    do_call(32'h700, 32'h74);
    idle(); stall = 1; ret_req = 1;
    tick(); idle();
    check("stall_ret_pc", pc_out, 32'h700);
    check("stall_ret_empty", {31'b0, ras_empty}, 32'd0);
    do_ret();
    check("stall_ret_pop", pc_out, 32'h74);

    for (int i = 1; i <= 5; i++) begin
      do_call(32'h1000 + 32'(i) * 32'h100, 32'(i) * 32'h10);
      check("call_tgt", pc_out, 32'h1000 + 32'(i) * 32'h100);
      check("ovf_flag", {31'b0, ras_overflow}, (i == 5) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      do_ret();
      check("ovf_ret", pc_out, exp_rets[i]);
    end
    check("ovf_drained", {31'b0, ras_empty}, 32'd1);

    do_call(32'h900, 32'h60);
    idle(); exc_req = 1; br_taken = 1; br_target = 32'h300; call_req = 1;
    jmp_target = 32'h500; link_addr = 32'h99C; stall = 1;
    tick(); idle();
    check("exc_pc", pc_out, 32'h180);
    check("exc_empty", {31'b0, ras_empty}, 32'd1);
    check("exc_redir", {31'b0, redirected}, 32'd1);
    check("exc_ovf_kept", {31'b0, ras_overflow}, 32'd1);
    do_ret();
    check("exc_no_push", pc_out, 32'h800);

    idle(); br_taken = 1; br_target = 32'h103;
    tick(); idle();
    check("misalign", pc_out, 32'h100);
    idle(); ret_req = 1; ret_fallback = 32'h7FF;
    tick(); idle();
    check("misalign_fb", pc_out, 32'h7FC);

    do_jmp(32'hFFFF_FFF8);
    tick(); check("hi_pc", pc_out, 32'hFFFF_FFFC);
    check("wrap_plus", pc_plus, 32'h0);
    tick(); check("wrap_pc", pc_out, 32'h0);
    check("wrap_redir", {31'b0, redirected}, 32'd0);

    // Asynchronous reset mid-operation.
    do_call(32'h240, 32'h44);
    @(posedge clk); reset = 1; #1;
    check("async_rst_pc", pc_out, 32'h0);
    check("async_rst_empty", {31'b0, ras_empty}, 32'd1);
    check("async_rst_ovf", {31'b0, ras_overflow}, 32'd0);
    check("async_rst_redir", {31'b0, redirected}, 32'd0);
    tick(); check("rst_hold", pc_out, 32'h0);
    reset = 0;
    tick(); check("post_rst", pc_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
